mux_scan_seq: RTL and testbench
===============================

Name: mux_scan_seq

Overview:
Parametrised, registered N-channel multiplexer with a built-in channel sequencer. It generalises the 8:1 single-bit mux to N_CH channels of W bits each. It adds two select modes:
- manual: select driven externally.
- scan: an internal counter steps through every channel, dwelling a fixed number of cycles on each.

It sits between a bank of sensor/data sources and a single shared downstream consumer (serialiser, ADC path, debug probe).

Parameters:
- N_CH, 8, number of input channels (2..256, need not be a power of 2).
- W, 1, bit width of each channel.
- DWELL, 4, cycles spent on each channel in scan mode (1..65535).
- SEL_W, $clog2(N_CH), select width. Derived localparam, not user-overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset.
- en  in  1  block enable; low freezes the block.
- mode  in  1  0 = manual select, 1 = auto scan.
- sel_in  in  SEL_W  manual channel select.
- din  in  N_CH*W  packed inputs; channel k occupies din[k*W +: W].
- dout  out  W  registered selected channel data.
- sel_out  out  SEL_W  channel index that dout currently reflects.
- valid  out  1  dout holds data from a legal, enabled selection.
- wrap  out  1  one-cycle pulse when scan steps from N_CH-1 back to 0.

Behaviour:
- Reset: one clock, synchronous, active-high on rst; all state registers reset on a rising clk edge with rst high.
  - Reset values: dout=0, sel_out=0, valid=0, wrap=0, dwell counter=0, state=IDLE.
  - rst overrides en, mode and every other input, including mid-scan.
- States: IDLE, MANUAL, SCAN. Next state is evaluated every cycle:
  - en=0: IDLE.
  - en=1, mode=0: MANUAL.
  - en=1, mode=1: SCAN.
- IDLE:
  - dout and sel_out hold their last values.
  - valid=0, wrap=0, dwell counter cleared.
- MANUAL:
  - Each cycle sel_out<=sel_in and dout<=din[sel_in].
  - Latency is 1 cycle from sel_in/din to dout.
  - Illegal select (sel_in>=N_CH, possible only when N_CH is not a power of 2): dout<=0, valid<=0, sel_out<=sel_in.
  - Otherwise valid<=1. wrap=0 throughout.
- SCAN:
  - Dwell counter runs 0..DWELL-1.
  - Counter < DWELL-1: counter increments, channel holds.
  - Counter = DWELL-1: counter goes to 0 and the channel advances by 1, or from N_CH-1 to 0.
  - dout<=din[next channel] every cycle, so data on the dwelled channel is re-sampled each cycle, not latched once.
  - valid=1.
- wrap:
  - Asserted for exactly the one cycle in which sel_out first shows 0 after being N_CH-1.
  - Never asserted on the first entry to SCAN.
- DWELL=1: channel advances every cycle; full sweep takes N_CH cycles.
- Mode transitions:
  - MANUAL->SCAN: scan starts from the current sel_out with the dwell counter at 0. If sel_out is illegal, scan starts at channel 0.
  - SCAN->MANUAL: takes effect on the next edge; the dwell counter is cleared.
- Enable:
  - Deasserting en mid-scan freezes the channel.
  - Reasserting en with mode=1 resumes from the frozen channel with the dwell counter at 0.
- Arithmetic:
  - Channel counter is SEL_W bits with explicit compare-to-(N_CH-1) wrap, never natural overflow.
  - Dwell counter width is $clog2(DWELL+1).
- No combinational path from any input to any output.

Decomposition:
- Shared package mux_pkg:
  - state encoding typedef (IDLE=2'd0, MANUAL=2'd1, SCAN=2'd2).
  - MODE_MANUAL/MODE_SCAN constants.
  - clog2 helper for tool flows lacking $clog2.
- One natural sub-module: scan_counter.
  - Contains the dwell counter plus channel counter with wrap pulse.
  - Inputs: clk, rst, run, load, load_val.
  - Outputs: ch, wrap.
- Top holds the state machine and the registered N_CH:1 data mux.

Test Plan:
All scenarios use N_CH=8, W=1, DWELL=4 unless noted.
- Reset: drive rst=1 for 2 cycles with en=1, mode=1, din=8'hFF -> dout=0, sel_out=0, valid=0, wrap=0 throughout; first scan edge occurs the cycle after rst falls.
- Manual walk: en=1, mode=0, din=8'b0000_0001.
  - Step sel_in 0..7, changing every 10 cycles.
  - Expect dout=1 only 1 cycle after sel_in=0; sel_out tracks sel_in with 1-cycle lag; valid=1.
  - Then set din[k] high progressively and confirm dout follows.
- Scan sweep: en=1, mode=1, din=8'b1010_1010.
  - sel_out holds each channel 4 cycles, visiting 0..7.
  - dout pattern is 0,1,0,1,... per 4-cycle block.
  - wrap pulses once, 32 cycles after the first advance into channel 0, and not at scan start.
- Freeze/resume: in scan on channel 5 at dwell count 2, drop en for 6 cycles.
  - During the freeze: sel_out=5, valid=0, dout held.
  - After en is raised again, channel 5 lasts a full 4 cycles before advancing to 6.
- Mode switches:
  - SCAN at channel 3 -> mode=0 with sel_in=6: next cycle sel_out=6.
  - Back to mode=1: scan starts at 6, after 4 cycles 7, then 0 with wrap=1.
- Illegal select: instance with N_CH=5, mode=0, sel_in=6 -> dout=0, valid=0, sel_out=6; switching to mode=1 starts scan at channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared types and helpers for the scanning N-channel multiplexer:
//            FSM state encoding, mode constants and a clog2 helper.
// Revision : 1.0  initial release
// ============================================================================
package mux_pkg;

  // Block operating state. Explicit 2-bit encoding; value 3 is unused.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Values of the mode input.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2 for flows without $clog2. clog2(1) = 0, clog2(8) = 3,
  // clog2(5) = 3.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_seq_if
// Purpose  : Bus bundle between data sources/control and the scanning mux.
//            master = control/source side, slave = the mux itself.
// Revision : 1.0  initial release
// ============================================================================
interface mux_scan_seq_if #(
  parameter int N_CH = 8,
  parameter int W    = 1
);
  import mux_pkg::*;

  localparam int SEL_W = clog2(N_CH);

  logic              en;
  logic              mode;
  logic [SEL_W-1:0]  sel_in;
  logic [N_CH*W-1:0] din;
  logic [W-1:0]      dout;
  logic [SEL_W-1:0]  sel_out;
  logic              valid;
  logic              wrap;

  modport master (
    output en, mode, sel_in, din,
    input  dout, sel_out, valid, wrap
  );

  modport slave (
    input  en, mode, sel_in, din,
    output dout, sel_out, valid, wrap
  );

endinterface
`default_nettype wire

// File: rtl/scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : scan_counter
// Purpose  : Dwell counter plus channel counter for scan mode. o_ch is the
//            channel the scan occupies after the coming edge (used by the
//            parent to register data); o_wrap is a registered pulse that
//            coincides with the channel stepping from N_CH-1 back to 0.
// Revision : 1.0  initial release
// ============================================================================
module scan_counter
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int DWELL = 4,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_load,
  input  logic [SEL_W-1:0] i_load_val,
  output logic [SEL_W-1:0] o_ch,
  output logic             o_wrap
);

  localparam int                CNT_W      = clog2(DWELL + 1);
  localparam logic [SEL_W:0]    c_N_CH     = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0]  c_LAST_CH  = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0]  c_LAST_CNT = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] r_ch;
  logic [SEL_W-1:0] w_ch_nxt;
  logic [SEL_W-1:0] w_load_ch;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;

  // Next channel/dwell/wrap: load restarts the dwell on a legal channel,
  // run steps the dwell and advances with an explicit last-channel compare.
  always_comb begin
    w_load_ch  = ({1'b0, i_load_val} < c_N_CH) ? i_load_val : '0;
    w_ch_nxt   = r_ch;
    w_cnt_nxt  = '0;
    w_wrap_nxt = 1'b0;
    if (i_load) begin
      w_ch_nxt = w_load_ch;
    end else if (i_run) begin
      if (r_cnt == c_LAST_CNT) begin
        if (r_ch == c_LAST_CH) begin
          w_ch_nxt   = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_ch_nxt = r_ch + 1'b1;
        end
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // Counter registers; when not running the channel holds and dwell clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch   <= '0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_ch   <= w_ch_nxt;
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign o_ch   = w_ch_nxt;
  assign o_wrap = r_wrap;

endmodule
`default_nettype wire

// File: rtl/mux_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_seq
// Purpose  : Registered N_CH:1 multiplexer of W-bit channels with manual
//            select or an automatic channel scan dwelling DWELL cycles on
//            each channel. All outputs come straight from registers.
// Revision : 1.0  initial release
// ============================================================================
module mux_scan_seq
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_seq_if.slave  bus
);

  localparam int             SEL_W  = clog2(N_CH);
  localparam logic [SEL_W:0] c_N_CH = (SEL_W + 1)'(N_CH);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [W-1:0]     w_ch_data [N_CH];
  logic             w_run;
  logic             w_load;
  logic [SEL_W-1:0] w_scan_ch;
  logic             w_wrap;
  logic [SEL_W-1:0] w_sel;
  logic             w_sel_legal;
  logic [W-1:0]     w_sel_data;

  logic [W-1:0]     r_dout;
  logic [SEL_W-1:0] r_sel_out;
  logic             r_valid;

  // Unpack the flat input bus into one entry per channel.
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign w_ch_data[k] = bus.din[k*W +: W];
  end

  // Next state follows en/mode directly every cycle.
  always_comb begin
    w_state_nxt = IDLE;
    if (bus.en) begin
      w_state_nxt = (bus.mode == MODE_SCAN) ? SCAN : MANUAL;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Scan restarts from the shown channel whenever SCAN is (re)entered.
  assign w_run  = (w_state_nxt == SCAN);
  assign w_load = w_run && (r_state != SCAN);

  scan_counter #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_scan_counter (
    .clk        (clk),
    .rst        (rst),
    .i_run      (w_run),
    .i_load     (w_load),
    .i_load_val (r_sel_out),
    .o_ch       (w_scan_ch),
    .o_wrap     (w_wrap)
  );

  // Single data mux shared by both modes; illegal selects yield zero data.
  always_comb begin
    w_sel       = (w_state_nxt == SCAN) ? w_scan_ch : bus.sel_in;
    w_sel_legal = ({1'b0, w_sel} < c_N_CH);
    w_sel_data  = w_sel_legal ? w_ch_data[w_sel] : '0;
  end

  // Output registers; IDLE holds data and index but drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout    <= '0;
      r_sel_out <= '0;
      r_valid   <= 1'b0;
    end else begin
      case (w_state_nxt)
        MANUAL, SCAN: begin
          r_sel_out <= w_sel;
          r_dout    <= w_sel_data;
          r_valid   <= w_sel_legal;
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout    = r_dout;
  assign bus.sel_out = r_sel_out;
  assign bus.valid   = r_valid;
  assign bus.wrap    = w_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_seq
// Purpose  : Self-checking bench for mux_scan_seq. Two instances: 8 x 1-bit
//            with DWELL=4, and 5 x 2-bit with DWELL=1 (illegal selects and
//            single-cycle dwell). A cycle-level model follows the behaviour
//            rules and is compared with both instances every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_scan_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [2:0]  sel_in;
  logic [63:0] din;

  int checks = 0;
  int errors = 0;

  mux_scan_seq_if #(.N_CH(8), .W(1)) bus8 ();
  mux_scan_seq_if #(.N_CH(5), .W(2)) bus5 ();

  assign bus8.en     = en;
  assign bus8.mode   = mode;
  assign bus8.sel_in = sel_in;
  assign bus8.din    = din[7:0];
  assign bus5.en     = en;
  assign bus5.mode   = mode;
  assign bus5.sel_in = sel_in;
  assign bus5.din    = din[9:0];

  mux_scan_seq #(.N_CH(8), .W(1), .DWELL(4)) u_dut8 (
    .clk (clk), .rst (rst), .bus (bus8)
  );

  mux_scan_seq #(.N_CH(5), .W(2), .DWELL(1)) u_dut5 (
    .clk (clk), .rst (rst), .bus (bus5)
  );

  always #5 clk = ~clk;

  // Expected view of one instance: what is shown, and how long it has shown
  // the current scan channel.
  typedef struct {
    bit scanning;
    int ch;
    int cyc;
    int sel;
    int dout;
    bit valid;
    bit wrap;
  } model_t;

  model_t m8;
  model_t m5;

  function automatic int field(input int ch, input int w);
    logic [63:0] v;
    v = (din >> (ch * w)) & ((64'd1 << w) - 64'd1);
    return int'(v[31:0]);
  endfunction

  function automatic model_t model_step(input model_t m, input int n,
                                        input int w, input int dwell);
    model_t r;
    r = m;
    r.wrap = 1'b0;
    if (rst) begin
      r = '{default: 0};
    end else if (!en) begin
      r.valid    = 1'b0;
      r.scanning = 1'b0;
    end else if (mode == 1'b0) begin
      r.scanning = 1'b0;
      r.sel      = int'(sel_in);
      if (r.sel < n) begin
        r.dout  = field(r.sel, w);
        r.valid = 1'b1;
      end else begin
        r.dout  = 0;
        r.valid = 1'b0;
      end
    end else begin
      if (!m.scanning) begin
        r.ch  = (m.sel < n) ? m.sel : 0;
        r.cyc = 1;
      end else if (m.cyc == dwell) begin
        r.ch   = (m.ch + 1) % n;
        r.wrap = (r.ch == 0);
        r.cyc  = 1;
      end else begin
        r.cyc = m.cyc + 1;
      end
      r.sel      = r.ch;
      r.dout     = field(r.ch, w);
      r.valid    = 1'b1;
      r.scanning = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the model on the edge, compare just after it.
  task automatic tick();
    @(posedge clk);
    m8 = model_step(m8, 8, 1, 4);
    m5 = model_step(m5, 5, 2, 1);
    #1;
    chk("n8.dout",    32'(bus8.dout),    32'(m8.dout));
    chk("n8.sel_out", 32'(bus8.sel_out), 32'(m8.sel));
    chk("n8.valid",   32'(bus8.valid),   32'(m8.valid));
    chk("n8.wrap",    32'(bus8.wrap),    32'(m8.wrap));
    chk("n5.dout",    32'(bus5.dout),    32'(m5.dout));
    chk("n5.sel_out", 32'(bus5.sel_out), 32'(m5.sel));
    chk("n5.valid",   32'(bus5.valid),   32'(m5.valid));
    chk("n5.wrap",    32'(bus5.wrap),    32'(m5.wrap));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wraps;
    int wrap_at;
    m8 = '{default: 0};
    m5 = '{default: 0};

    // Reset held while the block is told to scan all-ones data.
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel_in = 3'd0; din = '1;
    tick();
    tick();
    chk("rst.dout",  32'(bus8.dout),  32'd0);
    chk("rst.valid", 32'(bus8.valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("scan_start.sel",   32'(bus8.sel_out), 32'd0);
    chk("scan_start.valid", 32'(bus8.valid),   32'd1);
    chk("scan_start.dout",  32'(bus8.dout),    32'd1);

    // Manual walk over a single set bit, then fill bits progressively.
    mode = 1'b0; din = 64'h1;
    for (int s = 0; s < 8; s++) begin
      sel_in = 3'(s);
      tick();
      chk("walk.dout", 32'(bus8.dout), (s == 0) ? 32'd1 : 32'd0);
      repeat (9) tick();
    end
    for (int k = 0; k < 8; k++) begin
      din[k] = 1'b1;
      sel_in = 3'(k);
      tick();
      chk("fill.dout", 32'(bus8.dout), 32'd1);
    end

    // Full scan sweep from channel 0 over alternating data.
    sel_in = 3'd0; din = 64'h2AA;
    tick();
    mode = 1'b1;
    wraps = 0; wrap_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus8.wrap) begin
        wraps++;
        wrap_at = i;
      end
      if (i <= 32) begin
        chk("sweep.sel",  32'(bus8.sel_out), 32'((i - 1) / 4));
        chk("sweep.dout", 32'(bus8.dout),    32'(((i - 1) / 4) % 2));
      end
    end
    chk("sweep.wraps",   32'(wraps),   32'd1);
    chk("sweep.wrap_at", 32'(wrap_at), 32'd33);

    // Freeze on channel 5 at dwell count 2, then resume.
    mode = 1'b0; sel_in = 3'd5;
    tick();
    mode = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    repeat (6) begin
      tick();
      chk("freeze.sel",   32'(bus8.sel_out), 32'd5);
      chk("freeze.valid", 32'(bus8.valid),   32'd0);
      chk("freeze.dout",  32'(bus8.dout),    32'd1);
    end
    en = 1'b1;
    repeat (4) begin
      tick();
      chk("resume.sel", 32'(bus8.sel_out), 32'd5);
    end
    tick();
    chk("resume.adv", 32'(bus8.sel_out), 32'd6);

    // Mode switches in both directions, ending in a wrap.
    mode = 1'b0; sel_in = 3'd3;
    tick();
    mode = 1'b1;
    tick();
    tick();
    chk("mode.scan3", 32'(bus8.sel_out), 32'd3);
    mode = 1'b0; sel_in = 3'd6;
    tick();
    chk("mode.man6", 32'(bus8.sel_out), 32'd6);
    mode = 1'b1;
    repeat (4) begin
      tick();
      chk("mode.ch6", 32'(bus8.sel_out), 32'd6);
    end
    repeat (4) begin
      tick();
      chk("mode.ch7", 32'(bus8.sel_out), 32'd7);
      chk("mode.nowrap", 32'(bus8.wrap), 32'd0);
    end
    tick();
    chk("mode.ch0",  32'(bus8.sel_out), 32'd0);
    chk("mode.wrap", 32'(bus8.wrap),    32'd1);
    tick();
    chk("mode.wrap_end", 32'(bus8.wrap), 32'd0);

    // Illegal select on the 5-channel instance.
    mode = 1'b0; sel_in = 3'd6; din = 64'h3FF;
    tick();
    chk("illegal.dout",  32'(bus5.dout),    32'd0);
    chk("illegal.valid", 32'(bus5.valid),   32'd0);
    chk("illegal.sel",   32'(bus5.sel_out), 32'd6);
    mode = 1'b1;
    tick();
    chk("illegal.scan0", 32'(bus5.sel_out), 32'd0);
    chk("illegal.valid1", 32'(bus5.valid),  32'd1);

    // Randomised traffic, including occasional mid-scan resets.
    repeat (2000) begin
      rst    = ($urandom_range(0, 99) == 0);
      en     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel_in = 3'($urandom);
      din    = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
